// File: rtl/ntt_pkg.sv
// Shared NTT datapath definitions: mode encodings, defaults,
// and the Barrett constant helper.
package ntt_pkg;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

  localparam int WIDTH_DEF = 14;
  localparam int Q_DEF     = 12289;

  function automatic logic [63:0] barrett_mu(
    input int unsigned width,
    input int unsigned q
  );
    return (64'd1 << (2 * width)) / 64'(q);
  endfunction

endpackage

// File: rtl/bfu_pipe_if.sv
// Operand/result handshake bundle for the butterfly unit.
// slave = unit side, master = stage controller side.
interface bfu_pipe_if
  import ntt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] xin;
  logic [WIDTH-1:0] yin;
  logic [WIDTH-1:0] wr;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] xout;
  logic [WIDTH-1:0] yout;

  modport master (
    output in_valid, in_mode, xin, yin, wr, out_ready,
    input  in_ready, out_valid, out_mode, xout, yout
  );

  modport slave (
    input  in_valid, in_mode, xin, yin, wr, out_ready,
    output in_ready, out_valid, out_mode, xout, yout
  );

endinterface

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a 2*WIDTH-bit product
// into [0, Q).
module barrett_reduce
  import ntt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int Q     = Q_DEF
) (
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   res
);

  localparam int PW = 2 * WIDTH;
  localparam logic [PW:0]   MU = (PW+1)'(barrett_mu(WIDTH, Q));
  localparam logic [PW-1:0] QP = PW'(Q);

  logic [2*PW:0] full;
  logic [PW-1:0] est;
  logic [PW-1:0] r0;
  logic [PW-1:0] r1;
  logic [PW-1:0] r2;

  // estimate undershoots by at most 2, so r0 lies in [0, 3Q)
  always_comb begin
    full = (2*PW+1)'(prod) * (2*PW+1)'(MU);
    est  = PW'(full >> PW);
    r0   = prod - est * QP;
    r1   = (r0 >= QP) ? r0 - QP : r0;
    r2   = (r1 >= QP) ? r1 - QP : r1;
    res  = WIDTH'(r2);
  end

endmodule

// File: rtl/bfu_pipe.sv
// 4-stage pipelined CT/GS modular butterfly, one op per cycle.
// Define BFU_HALVE_EN to halve both GS outputs mod Q at S4.
module bfu_pipe
  import ntt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int Q     = Q_DEF
) (
  input  logic       clk,
  input  logic       reset,
  bfu_pipe_if.slave  bus,
  output logic       busy
);

  localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

  function automatic logic [WIDTH-1:0] mod_add(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QX) s = s - QX;
    return WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[WIDTH]) d = d + QX;
    return WIDTH'(d);
  endfunction

`ifdef BFU_HALVE_EN
  function automatic logic [WIDTH-1:0] half(
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH:0] t;
    t = v[0] ? {1'b0, v} + QX : {1'b0, v};
    return WIDTH'(t >> 1);
  endfunction
`endif

  logic             advance;
  logic             v1, v2, v3, v4;
  logic             m1, m2, m3, m4;
  logic [WIDTH-1:0] x1, y1, w1;
  logic [WIDTH-1:0] a2, a3, r3;
  logic [2*WIDTH-1:0] p2;
  logic [WIDTH-1:0] xo, yo;

  logic [WIDTH-1:0]   s1, d1, a_nxt, red;
  logic [WIDTH-1:0]   x_nxt, y_nxt;
  logic [2*WIDTH-1:0] p_nxt;

  // GS forms d*w in the same stage as d, so both modes share
  // the S2 product register and the single reducer.
  always_comb begin
    s1    = mod_add(x1, y1);
    d1    = mod_sub(x1, y1);
    a_nxt = (m1 == MODE_GS) ? s1 : x1;
    p_nxt = {{WIDTH{1'b0}}, (m1 == MODE_GS) ? d1 : y1}
          * {{WIDTH{1'b0}}, w1};
  end

  barrett_reduce #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_red (
    .prod (p2),
    .res  (red)
  );

  always_comb begin
    x_nxt = mod_add(a3, r3);
    y_nxt = mod_sub(a3, r3);
    if (m3 == MODE_GS) begin
`ifdef BFU_HALVE_EN
      x_nxt = half(a3);
      y_nxt = half(r3);
`else
      x_nxt = a3;
      y_nxt = r3;
`endif
    end
  end

  assign advance = !v4 || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      m1 <= 1'b0; m2 <= 1'b0; m3 <= 1'b0; m4 <= 1'b0;
      x1 <= '0; y1 <= '0; w1 <= '0;
      a2 <= '0; p2 <= '0;
      a3 <= '0; r3 <= '0;
      xo <= '0; yo <= '0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        m1 <= bus.in_mode;
        x1 <= bus.xin;
        y1 <= bus.yin;
        w1 <= bus.wr;
      end
      v2 <= v1;
      if (v1) begin
        m2 <= m1;
        a2 <= a_nxt;
        p2 <= p_nxt;
      end
      v3 <= v2;
      if (v2) begin
        m3 <= m2;
        a3 <= a2;
        r3 <= red;
      end
      v4 <= v3;
      if (v3) begin
        m4 <= m3;
        xo <= x_nxt;
        yo <= y_nxt;
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v4;
  assign bus.out_mode  = m4;
  assign bus.xout      = xo;
  assign bus.yout      = yo;
  assign busy          = v1 | v2 | v3 | v4;

endmodule

// File: tb/tb_bfu_pipe.sv
// Directed bench for bfu_pipe: latency, CT/GS values,
// backpressure, mid-stream reset.
module tb_bfu_pipe;

  localparam int W = 14;
  localparam int Q = 12289;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;

  bfu_pipe_if #(.WIDTH(W)) bus ();

  bfu_pipe #(
    .WIDTH (W),
    .Q     (Q)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int tx [8] = '{1, 5, 100, 20, 12288, 12288, 0, 3};
  int ty [8] = '{2, 10, 200, 7, 12288, 12288, 1000, 12288};
  int tw [8] = '{3, 4, 2, 3, 12288, 5, 1000, 2};
  int tm [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`ifdef BFU_HALVE_EN
  int ex [8] = '{7, 6152, 500, 6158, 0, 12288, 4591, 1};
  int ey [8] = '{12284, 12279, 11989, 6164, 12287, 0, 7698, 4};
`else
  int ex [8] = '{7, 15, 500, 27, 0, 12287, 4591, 2};
  int ey [8] = '{12284, 12269, 11989, 39, 12287, 0, 7698, 8};
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    bus.in_valid = 1'b1;
    bus.in_mode  = (tm[i] != 0);
    bus.xin      = W'(tx[i]);
    bus.yin      = W'(ty[i]);
    bus.wr       = W'(tw[i]);
  endtask

  task automatic single(input int i, input string tag);
    @(negedge clk);
    drive(i);
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
      #1;
      chk($sformatf("%s_v%0d", tag, k),
          32'(bus.out_valid), (k == 4) ? 1 : 0);
      if (k == 4) begin
        chk({tag, "_x"}, 32'(bus.xout), ex[i]);
        chk({tag, "_y"}, 32'(bus.yout), ey[i]);
        chk({tag, "_m"}, 32'(bus.out_mode), tm[i]);
      end
    end
    @(negedge clk);
    #1;
    chk({tag, "_drain"}, 32'(bus.out_valid), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int ni, no, stall, stale;
    logic held;
    logic [W-1:0] hx, hy;
    logic hm;

    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.xin       = '0;
    bus.yin       = '0;
    bus.wr        = '0;
    bus.out_ready = 1'b1;

    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x", 32'(bus.xout), 0);
    chk("rst_y", 32'(bus.yout), 0);
    chk("rst_mode", 32'(bus.out_mode), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    reset = 1'b1;

    single(0, "ct_basic");
    single(4, "ct_wrap");
    single(1, "gs");

    ni = 0; no = 0; stall = 0; held = 1'b0;
    hx = '0; hy = '0; hm = 1'b0;
    for (int cyc = 0; cyc < 40 && no < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      if (ni < 8) drive(ni);
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stall++;
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        if (held) begin
          chk("bp_hold_x", 32'(bus.xout), 32'(hx));
          chk("bp_hold_y", 32'(bus.yout), 32'(hy));
          chk("bp_hold_m", 32'(bus.out_mode), 32'(hm));
        end
        held = 1'b1;
        hx = bus.xout;
        hy = bus.yout;
        hm = bus.out_mode;
      end else begin
        held = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_x%0d", no), 32'(bus.xout), ex[no]);
        chk($sformatf("bp_y%0d", no), 32'(bus.yout), ey[no]);
        chk($sformatf("bp_m%0d", no), 32'(bus.out_mode), tm[no]);
        no++;
      end
      if (bus.in_valid && bus.in_ready) ni++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_count", no, 8);
    chk("bp_accepted", ni, 8);
    chk("bp_stall_cycles", stall, 3);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    chk("bp_no_dup", stale, 0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst_valid", 32'(bus.out_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_x", 32'(bus.xout), 0);
    chk("mrst_y", 32'(bus.yout), 0);
    chk("mrst_ready", 32'(bus.in_ready), 1);
    reset = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.out_valid || busy) stale++;
    end
    chk("mrst_no_stale", stale, 0);

    single(7, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
